ipg_rresp_gen: RTL
==================

# ipg_rresp_gen

Transmit-side generator for IPG read-response (RRESP) messages: the counterpart of the RRESP receiver. It accepts a response descriptor (header, source/destination memory address, chunk count) from the FakeDRAM responder plus a stream of 56-bit data chunks, and serialises them into 64-bit IPG blocks for the PHY's inter-packet-gap slots. Each message is FIRST(hdr), RRESP(src), RRESP(dst), RRESP(data)…, LAST(data).

## Interface
- `LEN_W`, 5: chunk-count width.
- `DEPTH`, 16: chunk FIFO depth, a power of 2 with DEPTH ≥ max message length.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  descriptor valid.
- `req_ready`  out  1  descriptor accepted when high with `req_valid`.
- `req_hdr`  in  56  response header; bits [15:0] are overwritten with `req_len`.
- `req_src_addr`  in  56  source memory address.
- `req_dst_addr`  in  56  destination memory address.
- `req_len`  in  LEN_W  data-chunk count. Legal range 1..DEPTH.
- `dat_valid`  in  1  chunk valid.
- `dat_ready`  out  1  chunk accepted; equals !fifo_full.
- `dat_chunk`  in  56  payload chunk.
- `tx_ipg_data`  out  64  {payload[55:0], block_type[7:0]}.
- `tx_len`  out  6  56 while `tx_valid`, else 0.
- `tx_valid`  out  1  block offered.
- `tx_ready`  in  1  IPG slot granted this cycle.
- `tx_last`  out  1  offered block is the LAST block.
- `busy`  out  1  state ≠ IDLE.
- `drop_pulse`  out  1  one-cycle pulse when a `req_len==0` descriptor is discarded.

## Operation
- Block types: FIRST=8'h2b, RRESP=8'h1b, LAST=8'h0b.
- FSM states: IDLE, WAIT_DATA, HDR, SRC, DST, DATA.
- IDLE:
  - `req_ready`=1.
  - On accept with len≥1: latch the descriptor, set remaining=len, go to WAIT_DATA.
  - On accept with len==0: pulse `drop_pulse` next cycle and stay in IDLE.
- WAIT_DATA: when fifo_count ≥ remaining, go to HDR. This guarantees a stall-free data phase from the generator side.
- HDR: offer {req_hdr[55:16], 16'(len), 8'h2b}; advance to SRC on handshake.
- SRC: offer {src, 8'h1b}; advance to DST on handshake.
- DST: offer {dst, 8'h1b}; advance to DATA on handshake.
- DATA:
  - Offer {fifo_head, type}, where type=8'h0b if remaining==1, else 8'h1b.
  - Each handshake pops the FIFO and decrements remaining.
  - The LAST handshake returns to IDLE.
- Handshake = `tx_valid` & `tx_ready`. While `tx_ready`=0, `tx_valid` and `tx_ipg_data` are held stable.
  - The slot arbiter must grant contiguous slots from FIRST to LAST, because the far-end receiver aborts a message on a gap. The generator never withdraws a block it has offered.
- FIFO:
  - Push on `dat_valid` & `dat_ready`; pop on a DATA handshake.
  - Push and pop in the same cycle leave the count unchanged and are legal at full, but `dat_ready`=0 at full, so that case cannot occur.
  - Pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
- Chunks are consumed strictly in order. Extra chunks pushed beyond a message's len stay in the FIFO for the next message.

## Timing
- Reset:
  - state=IDLE; FIFO pointers and count cleared.
  - `tx_valid`, `tx_last`, `busy`, `drop_pulse`, `tx_len`, `tx_ipg_data` = 0.
  - `req_ready`=1 and `dat_ready`=1 from the first cycle after reset.
  - A reset mid-message aborts the message without emitting LAST.
- Accept at cycle t → WAIT_DATA at t+1 → earliest `tx_valid` (HDR) at t+2, if data is already buffered.
- A message occupies len+3 handshake cycles; with `tx_ready` held at 1, the blocks are back to back.
- After the LAST handshake at cycle u, `req_ready`=1 at u+1. The minimum inter-message gap is 2 cycles without `tx_valid`.
- All outputs are driven from registered state, latched fields and the FIFO head. There is no combinational path from `tx_ready` to `tx_valid`/`tx_ipg_data`. `req_ready` and `dat_ready` are decoded from state and count.

## Structure
- Package `ipg_pkg`: the BLOCK_TYPE_FIRST/RRESP/LAST constants, the 56-bit payload width, the HDR length-field position [15:0], and the FSM state enum.
- Sub-module `ipg_chunk_fifo` (56-bit × DEPTH, synchronous, count output).
- FSM and framing mux live in the top level.

## Test plan
- Basic: hdr=56'h01001028900000, src=56'h1234567890ABCD, dst=56'h0000000000F0F0, len=2, chunks 56'hAAAAAAAAAAAAAA and 56'h55555555555555 preloaded, `tx_ready`=1.
  - Required blocks: 64'h010010289000022b, 64'h1234567890ABCD1b, 64'h0000000000F0F01b, 64'hAAAAAAAAAAAAAA1b, 64'h555555555555550b.
  - `tx_last` is high only on the fifth block.
- Stall: same message with `tx_ready`=0 for 3 cycles during SRC → the SRC block is held unchanged for those cycles; sequence and count (5) are identical.
- Late data: len=3 with chunks arriving 10 cycles after accept → `tx_valid` stays 0 until the third chunk is buffered, then the full message goes out back to back.
- Zero length: req_len=0 → accepted, `drop_pulse` for 1 cycle, no `tx_valid`, FIFO untouched.
- FIFO full: push DEPTH chunks with no request → `dat_ready`=0. A len=16 message then drains all 16, with LAST on the 16th, and `dat_ready` returns to 1 after the first pop.
- Reset mid-DATA: assert `reset` after 2 data handshakes of len=4 → the next cycle has all outputs 0 and count=0. A fresh len=1 message afterwards emits exactly 4 blocks, the last ending in 8'h0b.

Source files
------------

// File: rtl/ipg_pkg.sv
// Shared constants and FSM state type for the IPG read-response generator.
// Block layout is {payload[55:0], block_type[7:0]}.
package ipg_pkg;

    localparam int unsigned PAYLOAD_W = 56;
    localparam int unsigned BLOCK_W   = 64;

    localparam logic [7:0] BLOCK_TYPE_FIRST = 8'h2b;
    localparam logic [7:0] BLOCK_TYPE_RRESP = 8'h1b;
    localparam logic [7:0] BLOCK_TYPE_LAST  = 8'h0b;

    // Header bits carrying the chunk count.
    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_MSB = 15;
    localparam int unsigned HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    localparam logic [5:0] TX_LEN_BLOCK = 6'd56;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_HDR,
        ST_SRC,
        ST_DST,
        ST_DATA
    } state_t;

endpackage

// File: rtl/ipg_chunk_fifo.sv
// Synchronous chunk FIFO with occupancy count, head and one-ahead head_next
// so the generator can register the following data block on each pop.
module ipg_chunk_fifo #(
    parameter int unsigned DW    = 56,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DW-1:0]           wdata,
    input  logic                    pop,
    output logic [DW-1:0]           head,
    output logic [DW-1:0]           head_next,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;

    assign rd_ptr_nxt = rd_ptr + AW'(1);
    assign head       = mem[rd_ptr];
    assign head_next  = mem[rd_ptr_nxt];
    assign full       = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ipg_rresp_gen.sv
// IPG read-response generator: frames a descriptor plus buffered data chunks
// into FIRST/RRESP/.../LAST 64-bit blocks with registered, stall-stable outputs.
module ipg_rresp_gen
    import ipg_pkg::*;
#(
    parameter int unsigned LEN_W = 5,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [55:0]       req_hdr,
    input  logic [55:0]       req_src_addr,
    input  logic [55:0]       req_dst_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [55:0]       dat_chunk,
    output logic [63:0]       tx_ipg_data,
    output logic [5:0]        tx_len,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              drop_pulse
);

    state_t                 state;
    logic [LEN_W-1:0]       remaining;
    logic [PAYLOAD_W-1:0]   hdr_q;
    logic [PAYLOAD_W-1:0]   src_q;
    logic [PAYLOAD_W-1:0]   dst_q;

    logic [PAYLOAD_W-1:0]   fifo_head;
    logic [PAYLOAD_W-1:0]   fifo_head_next;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   data_buffered;

    // The header length field is replaced by req_len, so these bits are dropped.
    logic unused_hdr_len;
    assign unused_hdr_len = ^req_hdr[HDR_LEN_MSB:HDR_LEN_LSB];

    assign req_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign dat_ready     = !fifo_full;
    assign fifo_push     = dat_valid && dat_ready;
    assign fifo_pop      = (state == ST_DATA) && tx_valid && tx_ready;
    assign data_buffered = (32'(fifo_count) >= 32'(remaining));

    ipg_chunk_fifo #(
        .DW    (PAYLOAD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .wdata     (dat_chunk),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            hdr_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            tx_len      <= '0;
            tx_ipg_data <= '0;
            drop_pulse  <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_len == '0) begin
                            drop_pulse <= 1'b1;
                        end else begin
                            hdr_q     <= {req_hdr[PAYLOAD_W-1:HDR_LEN_MSB+1], HDR_LEN_W'(req_len)};
                            src_q     <= req_src_addr;
                            dst_q     <= req_dst_addr;
                            remaining <= req_len;
                            state     <= ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_buffered) begin
                        state       <= ST_HDR;
                        tx_valid    <= 1'b1;
                        tx_len      <= TX_LEN_BLOCK;
                        tx_ipg_data <= {hdr_q, BLOCK_TYPE_FIRST};
                    end
                end
                ST_HDR: begin
                    if (tx_ready) begin
                        state       <= ST_SRC;
                        tx_ipg_data <= {src_q, BLOCK_TYPE_RRESP};
                    end
                end
                ST_SRC: begin
                    if (tx_ready) begin
                        state       <= ST_DST;
                        tx_ipg_data <= {dst_q, BLOCK_TYPE_RRESP};
                    end
                end
                ST_DST: begin
                    if (tx_ready) begin
                        state       <= ST_DATA;
                        tx_last     <= (remaining == LEN_W'(1));
                        tx_ipg_data <= {fifo_head,
                                        (remaining == LEN_W'(1)) ? BLOCK_TYPE_LAST : BLOCK_TYPE_RRESP};
                    end
                end
                ST_DATA: begin
                    if (tx_ready) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state       <= ST_IDLE;
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            tx_len      <= '0;
                            tx_ipg_data <= '0;
                        end else begin
                            // The head is being popped this cycle, so the next block comes from one slot ahead.
                            tx_last     <= (remaining == LEN_W'(2));
                            tx_ipg_data <= {fifo_head_next,
                                            (remaining == LEN_W'(2)) ? BLOCK_TYPE_LAST : BLOCK_TYPE_RRESP};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
